// File: rtl/tilt_rate_limiter_if.sv
// Sample handshake and axis buses for the tilt slew-rate limiter.
// The master side supplies filtered samples; the slave side returns the
// slew-limited axes together with status flags.
interface tilt_rate_limiter_if;
  logic              data_ready;
  logic signed [9:0] accel_x_in;
  logic signed [9:0] accel_y_in;
  logic signed [9:0] accel_z_in;
  logic signed [9:0] accel_x_lim;
  logic signed [9:0] accel_y_lim;
  logic signed [9:0] accel_z_lim;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  modport master (
    output data_ready, accel_x_in, accel_y_in, accel_z_in,
    input  accel_x_lim, accel_y_lim, accel_z_lim, out_valid, busy, overrun
  );

  modport slave (
    input  data_ready, accel_x_in, accel_y_in, accel_z_in,
    output accel_x_lim, accel_y_lim, accel_z_lim, out_valid, busy, overrun
  );
endinterface

// File: rtl/tilt_rate_limiter.sv
// Tilt slew-rate limiter.
// Synchronises the filter's sample-valid level, captures one 3-axis sample
// per rising edge of it, then walks X, Y and Z through a single shared
// subtract/compare datapath, one axis per clock. Each axis output moves
// towards its input by at most MaxStep per sample, ignores errors within
// the deadband, and the first sample after reset is loaded directly.
// Samples arriving while a previous one is still in flight are dropped and
// flagged on the sticky overrun output.
module tilt_rate_limiter #(
  parameter int MaxStep  = 8,
  parameter int Deadband = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  tilt_rate_limiter_if.slave bus
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_AXIS_X = 3'd1;
  localparam logic [2:0] ST_AXIS_Y = 3'd2;
  localparam logic [2:0] ST_AXIS_Z = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // Thresholds widened to the 11-bit error width so comparisons never wrap.
  localparam logic signed [10:0] StepPos  = 11'(MaxStep);
  localparam logic signed [10:0] StepNeg  = 11'(-MaxStep);
  localparam logic        [10:0] DeadMag  = 11'(Deadband);
  localparam logic signed [9:0]  StepOut  = 10'(MaxStep);

  logic              sync1;
  logic              sync2;
  logic              sync3;
  logic              sync_rise;
  logic [2:0]        state;
  logic signed [9:0] cap_x;
  logic signed [9:0] cap_y;
  logic signed [9:0] cap_z;
  logic signed [9:0] lim_x;
  logic signed [9:0] lim_y;
  logic signed [9:0] lim_z;
  logic              primed;
  logic              out_valid;
  logic              overrun;

  logic signed [9:0]  sel_in;
  logic signed [9:0]  sel_out;
  logic signed [10:0] diff;
  logic        [10:0] mag;
  logic signed [9:0]  next_val;

  assign sync_rise = sync2 & ~sync3;

  assign bus.accel_x_lim = lim_x;
  assign bus.accel_y_lim = lim_y;
  assign bus.accel_z_lim = lim_z;
  assign bus.out_valid   = out_valid;
  assign bus.overrun     = overrun;
  assign bus.busy        = (state != ST_IDLE);

  // Two-flop synchroniser for the asynchronous sample-valid level plus a
  // history flop so a rising edge is seen exactly once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.data_ready;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Shared axis datapath: pick the axis of the current state and compute its
  // next output. Stepping by MaxStep only happens when the input lies beyond
  // that step, so the 10-bit sum can never leave the representable range.
  always_comb begin
    sel_in  = cap_x;
    sel_out = lim_x;
    case (state)
      ST_AXIS_Y: begin
        sel_in  = cap_y;
        sel_out = lim_y;
      end
      ST_AXIS_Z: begin
        sel_in  = cap_z;
        sel_out = lim_z;
      end
      default: begin
        sel_in  = cap_x;
        sel_out = lim_x;
      end
    endcase

    diff = {sel_in[9], sel_in} - {sel_out[9], sel_out};
    mag  = diff[10] ? 11'(-diff) : 11'(diff);

    if (!primed) begin
      next_val = sel_in;
    end else if (mag <= DeadMag) begin
      next_val = sel_out;
    end else if (diff > StepPos) begin
      next_val = sel_out + StepOut;
    end else if (diff < StepNeg) begin
      next_val = sel_out - StepOut;
    end else begin
      next_val = sel_in;
    end
  end

  // Sequencer: capture in IDLE, one axis per clock, then a completion pulse.
  // Edges seen outside IDLE (DONE included) drop the sample and set overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cap_x     <= '0;
      cap_y     <= '0;
      cap_z     <= '0;
      lim_x     <= '0;
      lim_y     <= '0;
      lim_z     <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sync_rise && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (sync_rise) begin
            cap_x <= bus.accel_x_in;
            cap_y <= bus.accel_y_in;
            cap_z <= bus.accel_z_in;
            state <= ST_AXIS_X;
          end
        end
        ST_AXIS_X: begin
          lim_x <= next_val;
          state <= ST_AXIS_Y;
        end
        ST_AXIS_Y: begin
          lim_y <= next_val;
          state <= ST_AXIS_Z;
        end
        ST_AXIS_Z: begin
          lim_z <= next_val;
          state <= ST_DONE;
        end
        ST_DONE: begin
          out_valid <= 1'b1;
          primed    <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tilt_rate_limiter.sv
// Self-checking bench for tilt_rate_limiter: directed scenarios plus a
// randomized run, all compared against a behavioural model of the limiter.
module tb_tilt_rate_limiter;

  localparam int MS = 8;
  localparam int DB = 2;

  logic clk;
  logic rst_n;
  int   pass_count;
  int   total_count;

  // Behavioural model state
  int mx, my, mz;
  bit mprimed;
  bit mover;

  tilt_rate_limiter_if bus ();

  tilt_rate_limiter #(.MaxStep(MS), .Deadband(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int step_axis(int inp, int cur, bit pr);
    int d;
    if (!pr) return inp;
    d = inp - cur;
    if (d <= DB && d >= -DB) return cur;
    if (d > MS) return cur + MS;
    if (d < -MS) return cur - MS;
    return inp;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; mz = 0; mprimed = 0; mover = 0;
  endtask

  task automatic model_apply(input int x, input int y, input int z);
    mx = step_axis(x, mx, mprimed);
    my = step_axis(y, my, mprimed);
    mz = step_axis(z, mz, mprimed);
    mprimed = 1;
  endtask

  // Hold reset for a few clocks, then release on a falling edge
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Present one sample, wait (bounded) for the completion pulse, then retire
  task automatic run_sample(input int x, input int y, input int z,
                            output bit got, output int lat, output bit after);
    @(negedge clk);
    bus.accel_x_in = 10'(x);
    bus.accel_y_in = 10'(y);
    bus.accel_z_in = 10'(z);
    bus.data_ready = 1'b1;
    got = 0; lat = 0; after = 1'b1;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        got = 1; lat = i;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      after = bus.out_valid;
    end
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.data_ready = 1'b0;
    bus.accel_x_in = '0; bus.accel_y_in = '0; bus.accel_z_in = '0;
    repeat (2) @(posedge clk);
    #1;
    total_count++;
    if (bus.accel_x_lim !== 10'sd0) $display("[TB] FAIL reset_x got %0d want 0", bus.accel_x_lim); else pass_count++;
    total_count++;
    if (bus.accel_y_lim !== 10'sd0) $display("[TB] FAIL reset_y got %0d want 0", bus.accel_y_lim); else pass_count++;
    total_count++;
    if (bus.accel_z_lim !== 10'sd0) $display("[TB] FAIL reset_z got %0d want 0", bus.accel_z_lim); else pass_count++;
    total_count++;
    if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", bus.out_valid); else pass_count++;
    total_count++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", bus.busy); else pass_count++;
    total_count++;
    if (bus.overrun !== 1'b0) $display("[TB] FAIL reset_overrun got %b want 0", bus.overrun); else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_primed_load();
    bit got, after; int lat;
    run_sample(100, -50, 300, got, lat, after);
    model_apply(100, -50, 300);
    total_count++;
    if (!got) $display("[TB] FAIL load_valid got none want pulse"); else pass_count++;
    total_count++;
    if (lat != 7) $display("[TB] FAIL load_latency got %0d want 7 edges after rise", lat); else pass_count++;
    total_count++;
    if (after !== 1'b0) $display("[TB] FAIL load_pulse_width got %b want 0", after); else pass_count++;
    total_count++;
    if ($signed(bus.accel_x_lim) != 100) $display("[TB] FAIL load_x got %0d want 100", bus.accel_x_lim); else pass_count++;
    total_count++;
    if ($signed(bus.accel_y_lim) != -50) $display("[TB] FAIL load_y got %0d want -50", bus.accel_y_lim); else pass_count++;
    total_count++;
    if ($signed(bus.accel_z_lim) != 300) $display("[TB] FAIL load_z got %0d want 300", bus.accel_z_lim); else pass_count++;
  endtask

  task automatic test_slew();
    bit got, after; int lat;
    int exp_x[6] = '{8, 16, 24, 32, 40, 40};
    do_reset();
    run_sample(0, 0, 0, got, lat, after);
    model_apply(0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_sample(40, 0, 0, got, lat, after);
      model_apply(40, 0, 0);
      total_count++;
      if (!got || after !== 1'b0) $display("[TB] FAIL slew_pulse[%0d] got valid=%b after=%b want 1/0", i, got, after); else pass_count++;
      total_count++;
      if ($signed(bus.accel_x_lim) != exp_x[i]) $display("[TB] FAIL slew_x[%0d] got %0d want %0d", i, bus.accel_x_lim, exp_x[i]); else pass_count++;
    end
  endtask

  task automatic test_deadband();
    bit got, after; int lat;
    int in_x[3]  = '{12, 7, 13};
    int exp_x[3] = '{10, 7, 13};
    do_reset();
    run_sample(10, 0, 0, got, lat, after);
    model_apply(10, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_sample(in_x[i], 0, 0, got, lat, after);
      model_apply(in_x[i], 0, 0);
      total_count++;
      if ($signed(bus.accel_x_lim) != exp_x[i]) $display("[TB] FAIL deadband_x[%0d] got %0d want %0d", i, bus.accel_x_lim, exp_x[i]); else pass_count++;
    end
  endtask

  task automatic test_boundary();
    bit got, after; int lat;
    do_reset();
    run_sample(0, 0, -508, got, lat, after);
    run_sample(0, 0, -512, got, lat, after);
    total_count++;
    if ($signed(bus.accel_z_lim) != -512) $display("[TB] FAIL bound_zneg got %0d want -512", bus.accel_z_lim); else pass_count++;
    do_reset();
    run_sample(0, 0, 505, got, lat, after);
    run_sample(0, 0, 511, got, lat, after);
    total_count++;
    if ($signed(bus.accel_z_lim) != 511) $display("[TB] FAIL bound_zpos got %0d want 511", bus.accel_z_lim); else pass_count++;
    do_reset();
    run_sample(511, -512, 0, got, lat, after);
    run_sample(-512, 511, 0, got, lat, after);
    total_count++;
    if ($signed(bus.accel_x_lim) != 503) $display("[TB] FAIL bound_xdown got %0d want 503", bus.accel_x_lim); else pass_count++;
    total_count++;
    if ($signed(bus.accel_y_lim) != -504) $display("[TB] FAIL bound_yup got %0d want -504", bus.accel_y_lim); else pass_count++;
    model_apply(511, -512, 0);
    model_apply(-512, 511, 0);
  endtask

  task automatic test_overrun();
    bit got, after; int lat; int pulses;
    do_reset();
    run_sample(0, 0, 0, got, lat, after);
    model_apply(0, 0, 0);
    // First rise before edge 1, so capture happens at edge 3
    @(negedge clk);
    bus.accel_x_in = 10'sd200; bus.accel_y_in = -10'sd100; bus.accel_z_in = 10'sd5;
    bus.data_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Second rise two clocks after capture, with different data
    bus.accel_x_in = -10'sd300; bus.accel_y_in = 10'sd300; bus.accel_z_in = -10'sd300;
    bus.data_ready = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    @(negedge clk);
    bus.data_ready = 1'b0;
    repeat (3) @(negedge clk);
    model_apply(200, -100, 5);
    mover = 1;
    total_count++;
    if (pulses != 1) $display("[TB] FAIL overrun_pulses got %0d want 1", pulses); else pass_count++;
    total_count++;
    if (bus.overrun !== mover) $display("[TB] FAIL overrun_flag got %b want %b", bus.overrun, mover); else pass_count++;
    total_count++;
    if ($signed(bus.accel_x_lim) != mx || $signed(bus.accel_y_lim) != my || $signed(bus.accel_z_lim) != mz)
      $display("[TB] FAIL overrun_data got %0d/%0d/%0d want %0d/%0d/%0d", bus.accel_x_lim, bus.accel_y_lim, bus.accel_z_lim, mx, my, mz);
    else pass_count++;
    run_sample(20, 20, 20, got, lat, after);
    model_apply(20, 20, 20);
    total_count++;
    if (bus.overrun !== 1'b1) $display("[TB] FAIL overrun_held got %b want 1", bus.overrun); else pass_count++;
    total_count++;
    if ($signed(bus.accel_x_lim) != mx) $display("[TB] FAIL overrun_next_x got %0d want %0d", bus.accel_x_lim, mx); else pass_count++;
  endtask

  task automatic test_reset_mid();
    bit got, after; int lat; int pulses;
    do_reset();
    run_sample(50, 60, 70, got, lat, after);
    model_apply(50, 60, 70);
    @(negedge clk);
    bus.accel_x_in = 10'sd90; bus.accel_y_in = 10'sd90; bus.accel_z_in = 10'sd90;
    bus.data_ready = 1'b1;
    // Edges 1..4: capture at 3, X updated at 4, now in AXIS_Y
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_count++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) $display("[TB] FAIL midreset_ctrl got busy=%b valid=%b want 0/0", bus.busy, bus.out_valid); else pass_count++;
    total_count++;
    if (bus.accel_x_lim !== 10'sd0 || bus.accel_y_lim !== 10'sd0 || bus.accel_z_lim !== 10'sd0)
      $display("[TB] FAIL midreset_out got %0d/%0d/%0d want 0/0/0", bus.accel_x_lim, bus.accel_y_lim, bus.accel_z_lim);
    else pass_count++;
    pulses = 0;
    @(negedge clk);
    bus.data_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    total_count++;
    if (pulses != 0) $display("[TB] FAIL midreset_pulses got %0d want 0", pulses); else pass_count++;
    run_sample(-200, 150, 400, got, lat, after);
    model_apply(-200, 150, 400);
    total_count++;
    if ($signed(bus.accel_x_lim) != -200 || $signed(bus.accel_y_lim) != 150 || $signed(bus.accel_z_lim) != 400)
      $display("[TB] FAIL midreset_unprimed got %0d/%0d/%0d want -200/150/400", bus.accel_x_lim, bus.accel_y_lim, bus.accel_z_lim);
    else pass_count++;
  endtask

  task automatic test_random();
    bit got, after; int lat;
    int x, y, z;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(1) == 0) begin
        x = int'($urandom_range(1023)) - 512;
        y = int'($urandom_range(1023)) - 512;
        z = int'($urandom_range(1023)) - 512;
      end else begin
        x = mx + int'($urandom_range(24)) - 12;
        y = my + int'($urandom_range(24)) - 12;
        z = mz + int'($urandom_range(24)) - 12;
        if (x > 511) x = 511; if (x < -512) x = -512;
        if (y > 511) y = 511; if (y < -512) y = -512;
        if (z > 511) z = 511; if (z < -512) z = -512;
      end
      run_sample(x, y, z, got, lat, after);
      model_apply(x, y, z);
      total_count++;
      if (!got || lat != 7) $display("[TB] FAIL rand_timing[%0d] got valid=%b lat=%0d want 1/7", n, got, lat); else pass_count++;
      total_count++;
      if ($signed(bus.accel_x_lim) != mx || $signed(bus.accel_y_lim) != my || $signed(bus.accel_z_lim) != mz)
        $display("[TB] FAIL rand_data[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", n, bus.accel_x_lim, bus.accel_y_lim, bus.accel_z_lim, mx, my, mz);
      else pass_count++;
    end
    total_count++;
    if (bus.overrun !== 1'b0) $display("[TB] FAIL rand_overrun got %b want 0", bus.overrun); else pass_count++;
  endtask

  initial begin
    pass_count = 0;
    total_count = 0;
    model_reset();
    test_reset();
    test_primed_load();
    test_slew();
    test_deadband();
    test_boundary();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule

// File: doc/tilt_rate_limiter.md
TILT_RATE_LIMITER -- requirements
Module: tilt_rate_limiter

Interface
REQ-001 Parameter MaxStep, default 8: largest per-update change of any output axis, in LSB; legal range 1..511.
REQ-002 Parameter Deadband, default 2: an error magnitude at or below this value leaves the output unchanged; legal range 0..MaxStep-1.
REQ-003 Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Rst_n  input  1  reset; synchronous, active-low.
REQ-005 DataReady  input  1  filter sample-valid level; asynchronous to Clk.
REQ-006 AccelXIn / AccelYIn / AccelZIn  input  10 each  signed filtered acceleration, stable while DataReady is high.
REQ-007 AccelXLim / AccelYLim / AccelZLim  output  10 each  signed slew-limited acceleration, registered.
REQ-008 OutValid  output  1  one-Clk pulse; limited outputs updated.
REQ-009 Busy  output  1  high while a sample is being processed (state not IDLE).
REQ-010 Overrun  output  1  sticky flag; a sample was dropped.

Function
REQ-011 DataReady shall pass through two synchronizer flops (S1, S2) and one history flop (S3); Edge = S2 & ~S3.
REQ-012 The FSM shall have states IDLE, AXIS_X, AXIS_Y, AXIS_Z, DONE, in that order.
REQ-013 In IDLE with Edge=1, the block shall latch all three inputs into capture registers and go to AXIS_X on the same edge.
REQ-014 AXIS_X, AXIS_Y and AXIS_Z shall each last exactly one Clk and update only their own axis, through one shared subtract/compare datapath.
REQ-015 DONE shall assert OutValid for one Clk and return to IDLE; OutValid is high in no other state.
REQ-016 Latency shall be 4 Clk from the capture edge to OutValid high, and 6-7 Clk from a DataReady rise.
REQ-017 Axis update: diff = In - Out, computed 11-bit signed with no overflow.
REQ-018 Axis update, deadband: if |diff| <= Deadband, Out shall be held.
REQ-019 Axis update, positive slew: else if diff > MaxStep, Out shall become Out+MaxStep.
REQ-020 Axis update, negative slew: else if diff < -MaxStep, Out shall become Out-MaxStep.
REQ-021 Axis update, settle: else Out shall become In.
REQ-022 Outputs shall never leave [-512, 511]; no wrap-around is permitted, including at -512 and 511.
REQ-023 Primed flag is cleared by reset. The first processed sample after reset shall load Out = In on all axes, with no limit and no deadband, then set Primed.
REQ-024 Edge while state is not IDLE: the new sample is discarded, Overrun is set and held until reset, and processing of the current sample continues unaffected.
REQ-025 Edge in the same cycle as DONE counts as not-IDLE: the sample is dropped and Overrun is set.
REQ-026 Capture registers shall not change between AXIS_X and DONE, even if the inputs change.

Reset
REQ-027 While Rst_n is low at a rising Clk: state=IDLE, all Lim outputs=0, OutValid=0, Busy=0, Overrun=0, Primed=0, S1..S3=0, capture registers=0.
REQ-028 Reset asserted mid-operation shall abort processing on the next Clk with no OutValid pulse; the partial axis update is discarded.
REQ-029 After release, the first Edge shall be treated as an unprimed sample (REQ-023).

Verification
REQ-030 Reset, then DataReady rise with X=100, Y=-50, Z=300 -> OutValid 4 Clk after capture; Lim = 100/-50/300 (primed load).
REQ-031 Primed at X=0, apply X=40 for six samples -> X outputs 8, 16, 24, 32, 40, 40; one OutValid per sample.
REQ-032 Primed at X=10, apply X=12, then 7, then 13 -> 10 (deadband), 7 (settle), 13 (settle: diff 6 is within MaxStep).
REQ-033 Primed at Z=-508, apply Z=-512; then at Z=505, apply Z=511 -> -512 and 511 exactly, with no wrap.
REQ-034 Second DataReady rise 2 Clk after the first capture -> exactly one OutValid, Overrun=1 and held, outputs reflect the first sample only.
REQ-035 Rst_n low during AXIS_Y -> no OutValid, all outputs 0, Busy 0 next Clk; a subsequent sample loads unprimed.
